wic_awake_ctrl: RTL and testbench
=================================

// Module: wic_awake_ctrl
// PURPOSE
//  Parametrised wake-up interrupt controller, successor to the fixed 32-source WIC.
//  - Synchronises NUM_INT raw interrupt sources and keeps a per-source pending flag.
//  - Pulse sources are latched until the CPU acknowledges the vector; level sources track their input.
//  - Runs a four-phase wake request handshake with the PMU while the core is in low power.
//  - Sits between SoC peripherals and the VIC/PMU, clocked by the always-on wic_clk.
// PARAMETERS
//  NUM_INT      32  number of interrupt sources, 1..64
//  VEC_W        6   ack/wake id width; must satisfy 2**VEC_W >= NUM_INT
//  SYNC_STAGES  2   input synchroniser depth on int_vld, 0..3 (0 = inputs already on wic_clk)
// PORTS
//  wic_clk          in   1        always-on WIC clock
//  pad_cpu_rst      in   1        asynchronous reset, active-high
//  int_vld          in   NUM_INT  raw interrupt sources
//  int_cfg          in   NUM_INT  per-source mode: 1 = pulse (edge-latched), 0 = level
//  awake_enable     in   NUM_INT  per-source wake mask
//  int_ack_vld      in   1        CPU is taking a vectored interrupt
//  int_ack_id       in   VEC_W    index of the interrupt being taken
//  cpu_in_lowpower  in   1        PMU: core is in wait/stop/doze
//  pmu_wake_ack     in   1        PMU acknowledge of wake request
//  int_pending      out  NUM_INT  pending flags to the VIC (pad_vic_int_vld)
//  intraw_vld       out  1        |(int_pending & awake_enable)
//  wic_pmu_wake_req out  1        wake request to the PMU
//  wake_id          out  VEC_W    lowest-index enabled pending source captured at request
// BEHAVIOUR
//  Reset:
//  - All flops clear: synchroniser, edge history, pending, ack history, FSM = IDLE.
//  - All outputs are 0.
//  Synchroniser:
//  - s_vld = int_vld delayed by SYNC_STAGES flops.
//  - Edge: rise[i] = s_vld[i] & ~s_vld_q[i], where s_vld_q is one more flop.
//  Ack decode:
//  - dec = onehot(int_ack_id) & {NUM_INT{int_ack_vld}}.
//  - int_ack_id >= NUM_INT decodes to all-zero; it is ignored, not an error.
//  - ack_clr = dec & ~dec_q, where dec_q is registered dec. One clear per acceptance;
//    holding int_ack_vld high clears only once.
//  Pending, registered:
//  - Pulse (cfg = 1): set on rise, clear on ack_clr. Set wins when both occur in one cycle.
//  - Level (cfg = 0): pending <= s_vld. ack_clr has no effect.
//  - int_cfg is sampled every cycle. Switching a bit from pulse to level discards the latched state.
//  - Latency int_vld -> int_pending is SYNC_STAGES+1 cycles for level sources and
//    SYNC_STAGES+2 cycles for pulse sources.
//  intraw_vld is combinational from the pending flops and awake_enable. It has no extra latency.
//  Wake FSM, states IDLE / REQ / HOLD:
//  - IDLE: go to REQ when cpu_in_lowpower & intraw_vld. On that cycle, wake_id captures the
//    lowest set bit of (pending & awake_enable).
//  - REQ: wic_pmu_wake_req = 1. Go to HOLD on pmu_wake_ack = 1. The request is never retracted,
//    even if intraw_vld falls. wake_id is frozen.
//  - HOLD: req = 0. Go to IDLE when pmu_wake_ack = 0 and cpu_in_lowpower = 0.
//  - wake_id holds its last captured value in IDLE. It is 0 only after reset.
//  - pmu_wake_ack seen in IDLE is ignored.
//  - Reset asserted mid-handshake returns the FSM to IDLE with req = 0 immediately (async).
// STRUCTURE
//  wic_pkg:
//  - wic_state_t enum: IDLE = 2'd0, REQ = 2'd1, HOLD = 2'd2.
//  - Parameter legality checks in an initial block: NUM_INT range, 2**VEC_W >= NUM_INT.
//  Sub-module wic_prio_enc #(NUM_INT, VEC_W):
//  - Combinational lowest-index-set finder: in[NUM_INT] -> idx[VEC_W], any.
//  - Used for wake_id capture.
//  Top level: synchroniser, edge/ack history, pending array, FSM.
// TESTING
//  1 Reset: pad_cpu_rst = 1 with int_vld = all-ones
//    -> int_pending = 0, req = 0, wake_id = 0.
//    Release -> level bits appear after 3 cycles (SYNC_STAGES = 2).
//  2 Pulse latch and clear: cfg[19] = 1; one-cycle pulse on int_vld[19]
//    -> pending[19] = 1 four cycles later and stays set.
//    int_ack_vld = 1, id = 19, held for 5 cycles -> pending[19] clears once, the next cycle.
//    A second pulse during the hold re-sets it.
//  3 Set/clear race: edge on bit 5 in the same cycle ack_clr[5] fires -> pending[5] remains 1.
//  4 Out-of-range ack: NUM_INT = 20, id = 25 -> no pending bit changes.
//  5 Wake handshake: lowpower = 1, enable = 32'h0000_0120, pending bits 8 and 5
//    -> req = 1, wake_id = 5.
//    Drop pending[5] before ack -> req stays 1.
//    Ack = 1 -> req = 0 next cycle.
//    Ack = 0 with lowpower still 1 -> FSM stays HOLD. lowpower = 0 -> IDLE.
//  6 Masked source: pending[3] = 1, awake_enable[3] = 0, lowpower = 1
//    -> intraw_vld = 0, no request. Assert enable[3] -> req = 1 the next cycle.

Source files
------------

// File: rtl/wic_awake_ctrl_pkg.sv
// Shared types and elaboration helpers for the wake-up interrupt controller.
package wic_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } wic_state_t;

    // Legal source count is 1..64 and every source must be addressable by an id.
    function automatic bit params_ok(int num_int, int vec_w);
        return (num_int >= 1) && (num_int <= 64) && (vec_w >= 1) && (vec_w <= 30)
               && ((1 << vec_w) >= num_int);
    endfunction

endpackage

// File: rtl/wic_awake_ctrl_if.sv
// Interrupt, CPU-ack and PMU handshake bundle of the wake-up interrupt controller.
interface wic_awake_ctrl_if #(
    parameter int NUM_INT = 32,
    parameter int VEC_W   = 6
);
    logic [NUM_INT-1:0] int_vld;
    logic [NUM_INT-1:0] int_cfg;
    logic [NUM_INT-1:0] awake_enable;
    logic               int_ack_vld;
    logic [VEC_W-1:0]   int_ack_id;
    logic               cpu_in_lowpower;
    logic               pmu_wake_ack;
    logic [NUM_INT-1:0] int_pending;
    logic               intraw_vld;
    logic               wic_pmu_wake_req;
    logic [VEC_W-1:0]   wake_id;

    modport master (
        output int_vld, int_cfg, awake_enable, int_ack_vld, int_ack_id,
               cpu_in_lowpower, pmu_wake_ack,
        input  int_pending, intraw_vld, wic_pmu_wake_req, wake_id
    );

    modport slave (
        input  int_vld, int_cfg, awake_enable, int_ack_vld, int_ack_id,
               cpu_in_lowpower, pmu_wake_ack,
        output int_pending, intraw_vld, wic_pmu_wake_req, wake_id
    );
endinterface

// File: rtl/wic_awake_ctrl_prio_enc.sv
// Lowest-index-set finder used to pick the wake id.
module wic_prio_enc #(
    parameter int NUM_INT = 32,
    parameter int VEC_W   = 6
) (
    input  logic [NUM_INT-1:0] in,
    output logic [VEC_W-1:0]   idx,
    output logic               any
);
    // Scan from the top so the lowest set bit is the last one written.
    always_comb begin
        idx = '0;
        for (int i = NUM_INT - 1; i >= 0; i--) begin
            if (in[i]) idx = VEC_W'(i);
        end
    end

    assign any = |in;
endmodule

// File: rtl/wic_awake_ctrl.sv
// Wake-up interrupt controller: input sync, pending flags, PMU wake handshake.
module wic_awake_ctrl
    import wic_pkg::*;
#(
    parameter int NUM_INT     = 32,
    parameter int VEC_W       = 6,
    parameter int SYNC_STAGES = 2
) (
    input  logic              wic_clk,
    input  logic              pad_cpu_rst,
    wic_awake_ctrl_if.slave   bus
);
    localparam logic [1:0] ST_IDLE = 2'(IDLE);
    localparam logic [1:0] ST_REQ  = 2'(REQ);
    localparam logic [1:0] ST_HOLD = 2'(HOLD);

    if (!params_ok(NUM_INT, VEC_W) || SYNC_STAGES < 0 || SYNC_STAGES > 3) begin : g_param_err
        $error("wic_awake_ctrl: illegal NUM_INT / VEC_W / SYNC_STAGES");
    end

    logic [NUM_INT-1:0] s_vld, s_vld_q, rise, rise_q;
    logic [NUM_INT-1:0] dec, dec_q, ack_clr;
    logic [NUM_INT-1:0] pending, pending_nxt;
    logic [VEC_W-1:0]   enc_idx, wake_id_q;
    logic               enc_any;
    logic [1:0]         state;

    if (SYNC_STAGES == 0) begin : g_nosync
        assign s_vld = bus.int_vld;
    end else begin : g_sync
        logic [SYNC_STAGES-1:0][NUM_INT-1:0] sync_q;
        always_ff @(posedge wic_clk or posedge pad_cpu_rst) begin
            if (pad_cpu_rst) begin
                sync_q <= '0;
            end else begin
                sync_q[0] <= bus.int_vld;
                for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
            end
        end
        assign s_vld = sync_q[SYNC_STAGES-1];
    end

    // Ids at or above NUM_INT match no lane and are silently dropped.
    always_comb begin
        dec = '0;
        for (int i = 0; i < NUM_INT; i++) begin
            dec[i] = bus.int_ack_vld && (bus.int_ack_id == VEC_W'(i));
        end
    end

    assign rise    = s_vld & ~s_vld_q;
    assign ack_clr = dec & ~dec_q;

    // Pulse lanes: registered edge sets (and beats a same-cycle clear). Level lanes follow s_vld.
    assign pending_nxt = (bus.int_cfg & (rise_q | (pending & ~ack_clr)))
                       | (~bus.int_cfg & s_vld);

    always_ff @(posedge wic_clk or posedge pad_cpu_rst) begin
        if (pad_cpu_rst) begin
            s_vld_q <= '0;
            rise_q  <= '0;
            dec_q   <= '0;
            pending <= '0;
        end else begin
            s_vld_q <= s_vld;
            rise_q  <= rise;
            dec_q   <= dec;
            pending <= pending_nxt;
        end
    end

    wic_prio_enc #(.NUM_INT(NUM_INT), .VEC_W(VEC_W)) u_prio_enc (
        .in  (pending & bus.awake_enable),
        .idx (enc_idx),
        .any (enc_any)
    );

    // Once raised, the request stays up until the PMU acks, whatever the sources do.
    always_ff @(posedge wic_clk or posedge pad_cpu_rst) begin
        if (pad_cpu_rst) begin
            state     <= ST_IDLE;
            wake_id_q <= '0;
        end else begin
            case (state)
                ST_IDLE: if (bus.cpu_in_lowpower && enc_any) begin
                    state     <= ST_REQ;
                    wake_id_q <= enc_idx;
                end
                ST_REQ:  if (bus.pmu_wake_ack) state <= ST_HOLD;
                ST_HOLD: if (!bus.pmu_wake_ack && !bus.cpu_in_lowpower) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.int_pending      = pending;
    assign bus.intraw_vld       = enc_any;
    assign bus.wic_pmu_wake_req = (state == ST_REQ);
    assign bus.wake_id          = wake_id_q;
endmodule

// File: tb/tb_wic_awake_ctrl.sv
// Self-checking bench: directed vectors and sequences, then random traffic against a history model.
module tb_wic_awake_ctrl;
    localparam int N = 20;
    localparam int W = 6;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    wic_awake_ctrl_if #(.NUM_INT(N), .VEC_W(W)) bus ();

    wic_awake_ctrl #(.NUM_INT(N), .VEC_W(W), .SYNC_STAGES(2)) dut (
        .wic_clk     (clk),
        .pad_cpu_rst (rst),
        .bus         (bus)
    );

    // Reference model: raw input history per sampled edge plus the handshake phase.
    logic [N-1:0] vh [5];
    logic [N-1:0] m_dec, m_pend;
    bit           m_req, m_hold;
    logic [W-1:0] m_wid;

    typedef struct {
        logic [N-1:0] vld;
        logic [N-1:0] en;
        logic [N-1:0] pend;
        logic         raw;
    } vec_t;
    vec_t tbl [5];

    function automatic logic [N-1:0] bitn(int i);
        return N'(1) << i;
    endfunction

    function automatic logic [W-1:0] lowest(logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return W'(i);
        return '0;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 5; k++) vh[k] = '0;
        m_dec = '0; m_pend = '0; m_req = 0; m_hold = 0; m_wid = '0;
    endtask

    // Level pending = input sampled two edges ago; pulse set = 0->1 seen three edges ago.
    task automatic model_step();
        logic [N-1:0] dec, clr, rise, pnew, hit;
        if (rst) begin
            model_reset();
            return;
        end
        for (int k = 4; k > 0; k--) vh[k] = vh[k-1];
        vh[0] = bus.int_vld;
        dec = '0;
        if (bus.int_ack_vld && int'(bus.int_ack_id) < N) dec[bus.int_ack_id] = 1'b1;
        clr   = dec & ~m_dec;
        m_dec = dec;
        rise  = vh[3] & ~vh[4];
        hit   = m_pend & bus.awake_enable;
        if (!m_req && !m_hold) begin
            if (bus.cpu_in_lowpower && hit != '0) begin
                m_req = 1;
                m_wid = lowest(hit);
            end
        end else if (m_req) begin
            if (bus.pmu_wake_ack) begin
                m_req = 0; m_hold = 1;
            end
        end else if (!bus.pmu_wake_ack && !bus.cpu_in_lowpower) begin
            m_hold = 0;
        end
        for (int i = 0; i < N; i++)
            pnew[i] = bus.int_cfg[i] ? (rise[i] | (m_pend[i] & ~clr[i])) : vh[2][i];
        m_pend = pnew;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic ticks(int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic chk_model(string tag);
        chk({tag, "_pend"}, 64'(bus.int_pending), 64'(m_pend));
        chk({tag, "_raw"},  64'(bus.intraw_vld), 64'(|(m_pend & bus.awake_enable)));
        chk({tag, "_req"},  64'(bus.wic_pmu_wake_req), 64'(m_req));
        chk({tag, "_wid"},  64'(bus.wake_id), 64'(m_wid));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{vld: 20'h00001, en: 20'h00001, pend: 20'h00001, raw: 1'b1};
        tbl[1] = '{vld: 20'h80000, en: 20'h7FFFF, pend: 20'h80000, raw: 1'b0};
        tbl[2] = '{vld: 20'hFFFFF, en: 20'h00000, pend: 20'hFFFFF, raw: 1'b0};
        tbl[3] = '{vld: 20'h0A0A0, en: 20'h00020, pend: 20'h0A0A0, raw: 1'b1};
        tbl[4] = '{vld: 20'h00000, en: 20'hFFFFF, pend: 20'h00000, raw: 1'b0};

        rst = 1'b1;
        bus.int_vld = '1; bus.int_cfg = '0; bus.awake_enable = '0;
        bus.int_ack_vld = 0; bus.int_ack_id = '0;
        bus.cpu_in_lowpower = 0; bus.pmu_wake_ack = 0;
        model_reset();
        ticks(2);

        // Reset state, then level latency of three edges.
        chk("rst_pend", 64'(bus.int_pending), 64'(0));
        chk("rst_req",  64'(bus.wic_pmu_wake_req), 64'(0));
        chk("rst_wid",  64'(bus.wake_id), 64'(0));
        chk("rst_raw",  64'(bus.intraw_vld), 64'(0));
        rst = 1'b0;
        ticks(2);
        chk("lvl_lat2", 64'(bus.int_pending), 64'(0));
        tick();
        chk("lvl_lat3", 64'(bus.int_pending), 64'(20'hFFFFF));
        bus.int_vld = '0;
        ticks(4);

        for (int t = 0; t < 5; t++) begin
            bus.int_vld = tbl[t].vld;
            bus.awake_enable = tbl[t].en;
            ticks(3);
            chk($sformatf("tbl%0d_pend", t), 64'(bus.int_pending), 64'(tbl[t].pend));
            chk($sformatf("tbl%0d_raw", t),  64'(bus.intraw_vld), 64'(tbl[t].raw));
        end
        bus.int_vld = '0; bus.awake_enable = '0;
        ticks(3);

        // Pulse latch, single clear under a held ack, re-set during the hold.
        bus.int_cfg = bitn(19);
        bus.int_vld = bitn(19); tick(); bus.int_vld = '0;
        ticks(2);
        chk("pulse_lat3", 64'(bus.int_pending), 64'(0));
        tick();
        chk("pulse_lat4", 64'(bus.int_pending), 64'(bitn(19)));
        ticks(3);
        chk("pulse_stays", 64'(bus.int_pending), 64'(bitn(19)));
        bus.int_ack_vld = 1; bus.int_ack_id = 6'd19;
        tick();
        chk("ack_clear", 64'(bus.int_pending), 64'(0));
        bus.int_vld = bitn(19); tick(); bus.int_vld = '0;
        ticks(2);
        chk("hold_pre", 64'(bus.int_pending), 64'(0));
        tick();
        chk("hold_reset", 64'(bus.int_pending), 64'(bitn(19)));
        tick();
        chk("ack_once", 64'(bus.int_pending), 64'(bitn(19)));
        bus.int_ack_vld = 0; tick();
        bus.int_ack_vld = 1; tick();
        chk("reack", 64'(bus.int_pending), 64'(0));
        bus.int_ack_vld = 0;

        // Set and clear on the same edge: set wins.
        bus.int_cfg = bitn(19) | bitn(5);
        bus.int_vld = bitn(5); tick(); bus.int_vld = '0;
        ticks(2);
        bus.int_ack_vld = 1; bus.int_ack_id = 6'd5;
        tick();
        chk("race_set_wins", 64'(bus.int_pending), 64'(bitn(5)));
        bus.int_ack_vld = 0; tick();

        // Ids beyond the source count are ignored.
        bus.int_ack_vld = 1; bus.int_ack_id = 6'd25; ticks(2);
        chk("ack_oor25", 64'(bus.int_pending), 64'(bitn(5)));
        bus.int_ack_id = 6'd20; ticks(2);
        chk("ack_oor20", 64'(bus.int_pending), 64'(bitn(5)));
        bus.int_ack_id = 6'd5; tick();
        chk("ack_inrange", 64'(bus.int_pending), 64'(0));
        bus.int_ack_vld = 0; bus.int_cfg = '0; tick();

        // Wake handshake.
        bus.int_vld = bitn(8) | bitn(5); bus.awake_enable = 20'h00120;
        ticks(3);
        chk("hs_pend", 64'(bus.int_pending), 64'(bitn(8) | bitn(5)));
        chk("hs_raw", 64'(bus.intraw_vld), 64'(1));
        chk("hs_noreq", 64'(bus.wic_pmu_wake_req), 64'(0));
        bus.cpu_in_lowpower = 1; tick();
        chk("hs_req", 64'(bus.wic_pmu_wake_req), 64'(1));
        chk("hs_wid5", 64'(bus.wake_id), 64'(5));
        bus.int_vld = bitn(8); ticks(3);
        chk("hs_drop5", 64'(bus.int_pending), 64'(bitn(8)));
        chk("hs_req_kept", 64'(bus.wic_pmu_wake_req), 64'(1));
        chk("hs_wid_frozen", 64'(bus.wake_id), 64'(5));
        bus.pmu_wake_ack = 1; tick();
        chk("hs_ack_drop", 64'(bus.wic_pmu_wake_req), 64'(0));
        bus.pmu_wake_ack = 0; ticks(2);
        chk("hs_hold", 64'(bus.wic_pmu_wake_req), 64'(0));
        bus.cpu_in_lowpower = 0; tick();
        chk("hs_idle_wid", 64'(bus.wake_id), 64'(5));
        bus.cpu_in_lowpower = 1; tick();
        chk("hs_req2", 64'(bus.wic_pmu_wake_req), 64'(1));
        chk("hs_wid8", 64'(bus.wake_id), 64'(8));

        // Asynchronous reset mid-request.
        rst = 1; #1;
        chk("arst_req", 64'(bus.wic_pmu_wake_req), 64'(0));
        chk("arst_wid", 64'(bus.wake_id), 64'(0));
        chk("arst_pend", 64'(bus.int_pending), 64'(0));
        tick();
        rst = 0; bus.cpu_in_lowpower = 0; bus.int_vld = '0; bus.awake_enable = '0;
        ticks(4);

        // Masked source, then enabled.
        bus.int_vld = bitn(3); bus.awake_enable = 20'hFFFF7; bus.cpu_in_lowpower = 1;
        ticks(3);
        chk("mask_pend", 64'(bus.int_pending), 64'(bitn(3)));
        chk("mask_raw", 64'(bus.intraw_vld), 64'(0));
        tick();
        chk("mask_noreq", 64'(bus.wic_pmu_wake_req), 64'(0));
        bus.awake_enable = '1; #1;
        chk("unmask_raw", 64'(bus.intraw_vld), 64'(1));
        tick();
        chk("unmask_req", 64'(bus.wic_pmu_wake_req), 64'(1));
        chk("unmask_wid", 64'(bus.wake_id), 64'(3));
        bus.pmu_wake_ack = 1; tick();
        bus.pmu_wake_ack = 0; bus.cpu_in_lowpower = 0; tick();

        // Random traffic against the model.
        rst = 1; tick(); rst = 0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 15) == 0) bus.int_cfg = N'($urandom);
            if ($urandom_range(0, 31) == 0) bus.awake_enable = N'($urandom);
            bus.int_vld = bus.int_vld ^ N'($urandom & $urandom & $urandom);
            bus.int_ack_vld = ($urandom_range(0, 2) == 0);
            bus.int_ack_id = W'($urandom_range(0, 31));
            if ($urandom_range(0, 7) == 0) bus.cpu_in_lowpower = ~bus.cpu_in_lowpower;
            if ($urandom_range(0, 3) == 0) bus.pmu_wake_ack = ~bus.pmu_wake_ack;
            if ($urandom_range(0, 499) == 0) begin
                rst = 1; model_reset(); #1;
                chk_model("rnd_arst");
                tick();
                rst = 0;
            end
            tick();
            chk_model("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
